combo_prog_ctrl: RTL



---
 rtl/sejf_pkg.sv | 28 ++
 rtl/lockout_timer.sv | 45 ++++
 rtl/combo_prog_ctrl.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/sejf_pkg.sv
// ---------------------------------------------------------------------------
// sejf_pkg
// Shared definitions for the safe's combination supervisor.
//   - state codes for the programming / lockout FSM
//   - default digit width
//   - digit-select codes driven by the master lock FSM
//   - prog_idx code shown while a staged combination awaits confirm
// ---------------------------------------------------------------------------
package sejf_pkg;

    localparam int DIGIT_W_DEF = 6;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE    = 3'd0;
    localparam state_t ST_CAP0    = 3'd1;
    localparam state_t ST_CAP1    = 3'd2;
    localparam state_t ST_CAP2    = 3'd3;
    localparam state_t ST_PCONF   = 3'd4;
    localparam state_t ST_LOCKOUT = 3'd5;

    localparam logic [1:0] SEL_D0 = 2'd0;
    localparam logic [1:0] SEL_D1 = 2'd1;
    localparam logic [1:0] SEL_D2 = 2'd2;

    localparam logic [1:0] PIDX_CONF = 2'd3;

endpackage

// File: rtl/lockout_timer.sv
// ---------------------------------------------------------------------------
// lockout_timer
// Loadable down-counter that times the entry lockout window.
// Ports:
//   clk_i      - clock, rising edge
//   rst_ni     - asynchronous active-low reset, counter clears to 0
//   load_i     - load load_val_i (has priority over counting)
//   load_val_i - value to load
//   en_i       - decrement by one per cycle while nonzero
//   zero_o     - counter currently equals zero
// ---------------------------------------------------------------------------
module lockout_timer #(
    parameter int W = 10
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         en_i,
    output logic         zero_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (en_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/combo_prog_ctrl.sv
// ---------------------------------------------------------------------------
// combo_prog_ctrl
// Combination store and supervisor for the safe.  Holds the three stored
// digits, serves the comparator's reference digit, sequences reprogramming
// while unlocked, and enforces a timed lockout after repeated bad entries.
// Ports:
//   clk          - clock, rising edge
//   rst          - asynchronous active-low reset
//   unlocked     - master FSM is in its unlocked state
//   prog_req     - pulse: start or cancel programming
//   confirm      - pulse: commit staged combination
//   dirch        - pulse: dial direction change, captures one digit
//   knob_val     - current dial position
//   sel          - digit select from master FSM
//   bad_attempt  - pulse: entry rejected
//   good_attempt - pulse: entry accepted
//   ref_digit    - stored digit chosen by sel (combinational)
//   prog_active  - in a programming state
//   prog_idx     - digit awaiting capture, 3 while awaiting confirm
//   lockout      - entry locked out
//   fail_cnt     - consecutive bad attempts
//   prog_done    - pulse: new combination committed
//   prog_err     - pulse: programming aborted or rejected
// ---------------------------------------------------------------------------
module combo_prog_ctrl
    import sejf_pkg::*;
#(
    parameter int                 DIGIT_W     = DIGIT_W_DEF,
    parameter int                 MAX_FAIL    = 3,
    parameter int                 LOCKOUT_CYC = 1000,
    parameter logic [DIGIT_W-1:0] DEF_C0      = 6'd10,
    parameter logic [DIGIT_W-1:0] DEF_C1      = 6'd20,
    parameter logic [DIGIT_W-1:0] DEF_C2      = 6'd30
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            unlocked,
    input  logic                            prog_req,
    input  logic                            confirm,
    input  logic                            dirch,
    input  logic [DIGIT_W-1:0]              knob_val,
    input  logic [1:0]                      sel,
    input  logic                            bad_attempt,
    input  logic                            good_attempt,
    output logic [DIGIT_W-1:0]              ref_digit,
    output logic                            prog_active,
    output logic [1:0]                      prog_idx,
    output logic                            lockout,
    output logic [$clog2(MAX_FAIL+1)-1:0]   fail_cnt,
    output logic                            prog_done,
    output logic                            prog_err
);

    localparam int FC_W  = $clog2(MAX_FAIL + 1);
    localparam int TMR_W = $clog2(LOCKOUT_CYC);

    localparam logic [DIGIT_W-1:0] DEF_C [3] = '{DEF_C0, DEF_C1, DEF_C2};

    // ------------------------------------------------------------------
    // State and registered outputs
    // ------------------------------------------------------------------
    state_t          state_q, state_d;
    logic            prog_active_q, prog_active_d;
    logic [1:0]      prog_idx_q, prog_idx_d;
    logic            lockout_q, lockout_d;
    logic [FC_W-1:0] fail_cnt_q, fail_cnt_d;
    logic            prog_done_q, prog_done_d;
    logic            prog_err_q, prog_err_d;

    // Events decided by the next-state logic
    logic            commit_ev;
    logic            err_ev;
    logic            cap_ev;
    logic            lock_ev;
    logic            lock_exit_ev;
    logic [1:0]      cap_idx;

    logic [DIGIT_W-1:0] c_q [3];
    logic [DIGIT_W-1:0] s_q [3];

    logic tmr_zero;
    logic in_prog;
    logic count_bad;

    assign in_prog   = (state_q == ST_CAP0) || (state_q == ST_CAP1) ||
                       (state_q == ST_CAP2) || (state_q == ST_PCONF);
    // Attempts only count while idle; programming ignores them.
    assign count_bad = (state_q == ST_IDLE) && bad_attempt;

    // ------------------------------------------------------------------
    // State register (with registered outputs)
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= ST_IDLE;
            prog_active_q <= 1'b0;
            prog_idx_q    <= 2'd0;
            lockout_q     <= 1'b0;
            fail_cnt_q    <= '0;
            prog_done_q   <= 1'b0;
            prog_err_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            prog_active_q <= prog_active_d;
            prog_idx_q    <= prog_idx_d;
            lockout_q     <= lockout_d;
            fail_cnt_q    <= fail_cnt_d;
            prog_done_q   <= prog_done_d;
            prog_err_q    <= prog_err_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        commit_ev    = 1'b0;
        err_ev       = 1'b0;
        cap_ev       = 1'b0;
        lock_ev      = 1'b0;
        lock_exit_ev = 1'b0;
        cap_idx      = 2'd0;
        unique case (state_q)
            ST_IDLE: begin
                // A lockout-triggering bad attempt beats a simultaneous
                // programming request.
                if (count_bad && (fail_cnt_q == FC_W'(MAX_FAIL - 1))) begin
                    lock_ev = 1'b1;
                    state_d = ST_LOCKOUT;
                end else if (prog_req && unlocked) begin
                    state_d = ST_CAP0;
                end
            end
            ST_CAP0, ST_CAP1, ST_CAP2, ST_PCONF: begin
                // Losing the unlocked state aborts before anything else.
                if (!unlocked || prog_req) begin
                    err_ev  = 1'b1;
                    state_d = ST_IDLE;
                end else if (state_q == ST_PCONF) begin
                    if (confirm) begin
                        state_d = ST_IDLE;
                        // A combination of three equal digits is refused.
                        if ((s_q[0] == s_q[1]) && (s_q[1] == s_q[2])) begin
                            err_ev = 1'b1;
                        end else begin
                            commit_ev = 1'b1;
                        end
                    end
                end else if (dirch) begin
                    cap_ev  = 1'b1;
                    cap_idx = 2'(state_q - ST_CAP0);
                    state_d = state_q + 3'd1;
                end
            end
            ST_LOCKOUT: begin
                if (tmr_zero) begin
                    lock_exit_ev = 1'b1;
                    state_d      = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Output logic (values loaded into the output registers)
    // ------------------------------------------------------------------
    always_comb begin
        prog_active_d = 1'b0;
        prog_idx_d    = 2'd0;
        lockout_d     = (state_d == ST_LOCKOUT);
        prog_done_d   = commit_ev;
        prog_err_d    = err_ev;
        fail_cnt_d    = fail_cnt_q;
        unique case (state_d)
            ST_CAP0:  begin prog_active_d = 1'b1; prog_idx_d = SEL_D0;    end
            ST_CAP1:  begin prog_active_d = 1'b1; prog_idx_d = SEL_D1;    end
            ST_CAP2:  begin prog_active_d = 1'b1; prog_idx_d = SEL_D2;    end
            ST_PCONF: begin prog_active_d = 1'b1; prog_idx_d = PIDX_CONF; end
            default:  begin prog_active_d = 1'b0; prog_idx_d = 2'd0;      end
        endcase
        if (lock_exit_ev) begin
            fail_cnt_d = '0;
        end else if (count_bad) begin
            fail_cnt_d = fail_cnt_q + 1'b1;
        end else if ((state_q == ST_IDLE) && good_attempt) begin
            fail_cnt_d = '0;
        end
    end

    assign prog_active = prog_active_q;
    assign prog_idx    = prog_idx_q;
    assign lockout     = lockout_q;
    assign fail_cnt    = fail_cnt_q;
    assign prog_done   = prog_done_q;
    assign prog_err    = prog_err_q;

    // ------------------------------------------------------------------
    // Staged and committed digit registers
    // ------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_digit
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    s_q[gi] <= '0;
                    c_q[gi] <= DEF_C[gi];
                end else begin
                    if (cap_ev && (cap_idx == 2'(gi))) begin
                        s_q[gi] <= knob_val;
                    end
                    if (commit_ev) begin
                        c_q[gi] <= s_q[gi];
                    end
                end
            end
        end
    endgenerate

    // Reference digit is combinational so the comparator sees no latency.
    always_comb begin
        unique case (sel)
            SEL_D0:  ref_digit = c_q[0];
            SEL_D1:  ref_digit = c_q[1];
            SEL_D2:  ref_digit = c_q[2];
            default: ref_digit = '0;
        endcase
    end

    // ------------------------------------------------------------------
    // Lockout timer: loaded on entry so lockout lasts LOCKOUT_CYC cycles
    // ------------------------------------------------------------------
    lockout_timer #(
        .W (TMR_W)
    ) u_lockout_timer (
        .clk_i      (clk),
        .rst_ni     (rst),
        .load_i     (lock_ev),
        .load_val_i (TMR_W'(LOCKOUT_CYC - 1)),
        .en_i       (state_q == ST_LOCKOUT),
        .zero_o     (tmr_zero)
    );

endmodule
